// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Multiplexed 7-segment scan controller for 1..8 digits with a
//            per-frame input snapshot, per-digit blink and blanking,
//            leading-zero blanking and an anti-ghosting guard interval.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blink,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lzb_en,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_start
);

  localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]     P_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     P_GUARD  = PW'(GUARD);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [FW-1:0]     FC_LAST  = FW'(BLINK_FRAMES - 1);
  // XOR masks that turn active-high internal values into pin polarity
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]         p;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         fc;
  logic                  phase;

  logic [4*DIGITS-1:0]   snap_data;
  logic [DIGITS-1:0]     snap_point;
  logic [DIGITS-1:0]     snap_blink;
  logic [DIGITS-1:0]     snap_blank;
  logic                  snap_lzb_en;

  logic                  slot_wrap;
  logic                  frame_end;
  logic [7*DIGITS-1:0]   dec;
  logic [DIGITS-1:0]     dark;
  logic [7:0]            seg_act;
  logic [DIGITS-1:0]     an_act;

  // Standard hex to a..g decode, active-high, bit0 = a
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_wrap = (p == P_LAST);
  assign frame_end = slot_wrap && (idx == IDX_LAST);

  // Per-digit decode and darkness; leading zeros are judged from the top
  // digit down, so digit k is blanked only when it and everything above it
  // is zero. Digit 0 always shows something unless blanked or blinking.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic lz;
    if (k == 0) begin : g_lsd
      assign lz = 1'b0;
    end else begin : g_upper
      assign lz = snap_lzb_en && (snap_data[4*DIGITS-1:4*k] == '0);
    end
    assign dark[k]        = snap_blank[k] | (snap_blink[k] & phase) | lz;
    assign dec[7*k +: 7]  = hex7(snap_data[4*k +: 4]);
  end

  // Scan counters, frame counter, blink phase and frame snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      idx         <= '0;
      fc          <= '0;
      phase       <= 1'b0;
      snap_data   <= '0;
      snap_point  <= '0;
      snap_blink  <= '0;
      snap_blank  <= '0;
      snap_lzb_en <= 1'b0;
    end else begin
      if (slot_wrap) begin
        p   <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        p   <= p + 1'b1;
      end
      if (frame_end) begin
        snap_data   <= data;
        snap_point  <= point;
        snap_blink  <= blink;
        snap_blank  <= blank;
        snap_lzb_en <= lzb_en;
        if (fc == FC_LAST) begin
          fc    <= '0;
          phase <= ~phase;
        end else begin
          fc    <= fc + 1'b1;
        end
      end
    end
  end

  // Active-high view of what the pins should show for the current state
  always_comb begin
    seg_act = 8'h00;
    an_act  = '0;
    if (p >= P_GUARD) begin
      for (int k = 0; k < DIGITS; k++) begin
        if ((idx == IW'(k)) && !dark[k]) begin
          seg_act   = {snap_point[k], dec[7*k +: 7]};
          an_act[k] = 1'b1;
        end
      end
    end
  end

  // Registered pin drivers with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      segment     <= SEG_OFF;
      anode       <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      segment     <= seg_act ^ SEG_OFF;
      anode       <= an_act ^ AN_OFF;
      frame_start <= frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Directed self-checking bench for seg7_scan_ctrl
//            (DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2, ACTIVE_LOW=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  point;
  logic [3:0]  blink;
  logic [3:0]  blank;
  logic        lzb_en;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  logic [3:0] an_cap  [16];
  logic [7:0] seg_cap [16];
  logic       fs_cap  [16];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .point(point), .blink(blink),
    .blank(blank), .lzb_en(lzb_en), .segment(segment), .anode(anode),
    .frame_start(frame_start)
  );

  // Expected anode pins for sample i of a frame (slot i/4, prescaler i%4)
  function automatic logic [3:0] exp_anode(input int i, input logic [3:0] dk);
    logic [3:0] one;
    int d;
    one = 4'b0001;
    d = i / 4;
    if ((i % 4) == 0 || dk[d]) return 4'hF;
    return ~(one << d);
  endfunction

  // Expected segment pins; segs holds active-high digit k patterns at [8k+:8]
  function automatic logic [7:0] exp_segment(input int i, input logic [3:0] dk,
                                             input logic [31:0] segs);
    int d;
    d = i / 4;
    if ((i % 4) == 0 || dk[d]) return 8'hFF;
    return ~segs[8*d +: 8];
  endfunction

  task automatic apply(input logic [15:0] d, input logic [3:0] pt,
                       input logic [3:0] bl, input logic [3:0] bk, input logic lz);
    @(posedge clk);
    #1;
    data = d; point = pt; blink = bl; blank = bk; lzb_en = lz;
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (frame_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      errors++; checks++;
      $display("FAIL frame_start_timeout: got no pulse, required one within 40 cycles");
    end
  endtask

  // chain=1 continues straight from a frame_start sample already observed
  task automatic capture_frame(input bit chain);
    if (!chain) begin
      @(posedge clk);
      wait_fs();
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      an_cap[i]  = anode;
      seg_cap[i] = segment;
      fs_cap[i]  = frame_start;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data = '0; point = '0; blink = '0; blank = '0; lzb_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode: got %h, required f", anode); end
    checks++; if (segment !== 8'hFF) begin errors++; $display("FAIL reset_segment: got %h, required ff", segment); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b, required 0", frame_start); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (anode !== 4'hF || segment !== 8'hFF) begin errors++; $display("FAIL first_guard: got an=%h seg=%h, required f/ff", anode, segment); end
    @(negedge clk);
    checks++; if (anode !== 4'hE || segment !== 8'hC0) begin errors++; $display("FAIL first_digit0: got an=%h seg=%h, required e/c0", anode, segment); end
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b0000) || seg_cap[i] !== exp_segment(i, 4'b0000, 32'h3F3F3F3F)) begin
        errors++;
        $display("FAIL zero_frame[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, an_cap[i], seg_cap[i],
                 exp_anode(i, 4'b0000), exp_segment(i, 4'b0000, 32'h3F3F3F3F));
      end
    end
  endtask

  task automatic test_display();
    apply(16'h12AF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    capture_frame(1'b0);
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b0000) || seg_cap[i] !== exp_segment(i, 4'b0000, 32'h065B7771)
          || fs_cap[i] !== (i == 15)) begin
        errors++;
        $display("FAIL display_12af[%0d]: got an=%h seg=%h fs=%b, required an=%h seg=%h fs=%b", i, an_cap[i], seg_cap[i],
                 fs_cap[i], exp_anode(i, 4'b0000), exp_segment(i, 4'b0000, 32'h065B7771), (i == 15));
      end
    end
  endtask

  task automatic test_frame_spacing();
    bit found;
    int cnt;
    found = 1'b0;
    cnt = 0;
    @(posedge clk);
    wait_fs();
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      cnt++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found || cnt != 16) begin
      errors++;
      $display("FAIL frame_spacing: got %0d cycles (found=%0d), required 16", cnt, found);
    end
  endtask

  task automatic test_mid_frame();
    @(posedge clk);
    wait_fs();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (anode !== exp_anode(i, 4'b0000) || segment !== exp_segment(i, 4'b0000, 32'h065B7771)) begin
        errors++;
        $display("FAIL mid_frame_hold[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, anode, segment,
                 exp_anode(i, 4'b0000), exp_segment(i, 4'b0000, 32'h065B7771));
      end
      if (i == 5) data = 16'h3456;
    end
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b0000) || seg_cap[i] !== exp_segment(i, 4'b0000, 32'h4F666D7D)) begin
        errors++;
        $display("FAIL mid_frame_new[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, an_cap[i], seg_cap[i],
                 exp_anode(i, 4'b0000), exp_segment(i, 4'b0000, 32'h4F666D7D));
      end
    end
  endtask

  task automatic test_lzb();
    apply(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b1100) || seg_cap[i] !== exp_segment(i, 4'b1100, 32'h00006D3F)) begin
        errors++;
        $display("FAIL lzb_0050[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, an_cap[i], seg_cap[i],
                 exp_anode(i, 4'b1100), exp_segment(i, 4'b1100, 32'h00006D3F));
      end
    end
  endtask

  task automatic test_lzb_all_zero();
    apply(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b1110) || seg_cap[i] !== exp_segment(i, 4'b1110, 32'h0000003F)) begin
        errors++;
        $display("FAIL lzb_0000[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, an_cap[i], seg_cap[i],
                 exp_anode(i, 4'b1110), exp_segment(i, 4'b1110, 32'h0000003F));
      end
    end
  endtask

  task automatic test_point_blank();
    apply(16'h12AF, 4'b0100, 4'b0000, 4'b1000, 1'b0);
    capture_frame(1'b0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (an_cap[i] !== exp_anode(i, 4'b1000) || seg_cap[i] !== exp_segment(i, 4'b1000, 32'h06DB7771)) begin
        errors++;
        $display("FAIL point_blank[%0d]: got an=%h seg=%h, required an=%h seg=%h", i, an_cap[i], seg_cap[i],
                 exp_anode(i, 4'b1000), exp_segment(i, 4'b1000, 32'h06DB7771));
      end
    end
  endtask

  // From reset, frame k after the k-th frame_start has phase (k/2)%2
  task automatic test_blink();
    logic [3:0] dk;
    @(posedge clk);
    #1;
    rst = 1'b1; data = 16'h12AF; point = '0; blink = 4'b0001; blank = '0; lzb_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      capture_frame(k != 1);
      dk = (((k / 2) % 2) == 1) ? 4'b0001 : 4'b0000;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (an_cap[i] !== exp_anode(i, dk) || seg_cap[i] !== exp_segment(i, dk, 32'h065B7771)) begin
          errors++;
          $display("FAIL blink_frame%0d[%0d]: got an=%h seg=%h, required an=%h seg=%h", k, i, an_cap[i],
                   seg_cap[i], exp_anode(i, dk), exp_segment(i, dk, 32'h065B7771));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    apply(16'h12AF, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    @(posedge clk);
    wait_fs();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (anode !== 4'hF || segment !== 8'hFF || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got an=%h seg=%h fs=%b, required f/ff/0", anode, segment, frame_start);
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      checks++;
      if (anode !== exp_anode(j, 4'b0000) || segment !== exp_segment(j, 4'b0000, 32'h3F3F3F3F)
          || frame_start !== (j == 15)) begin
        errors++;
        $display("FAIL midreset_restart[%0d]: got an=%h seg=%h fs=%b, required an=%h seg=%h fs=%b", j, anode,
                 segment, frame_start, exp_anode(j, 4'b0000), exp_segment(j, 4'b0000, 32'h3F3F3F3F), (j == 15));
      end
    end
  endtask

  initial begin
    test_reset();
    test_display();
    test_frame_spacing();
    test_mid_frame();
    test_lzb();
    test_lzb_all_zero();
    test_point_blank();
    test_blink();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
